// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: state encoding, output bundles and sizing helper for pipeline_ctrl
package pipeline_ctrl_pkg;
  typedef enum logic [2:0] {BOOT, RUN, LOAD_STALL, MEM_WAIT, DRAIN, HALT} ctrl_state_e;
  typedef struct packed {
    logic pc_en;
    logic pc_sel;
    logic if_de_en;
    logic if_de_flush;
    logic de_mw_en;
    logic de_mw_flush;
  } ctrl_out_t;
  localparam int CNT_W_DEF = 16;
  localparam int BOOT_CYC_DEF = 2;
  localparam int LOAD_STALL_CYC_DEF = 1;
  localparam int DRAIN_CYC_DEF = 2;
  localparam ctrl_out_t OUT_FREEZE = ctrl_out_t'(6'b000000);
  localparam ctrl_out_t OUT_RUN    = ctrl_out_t'(6'b101010);
  localparam ctrl_out_t OUT_BOOT   = ctrl_out_t'(6'b000101);
  localparam ctrl_out_t OUT_BUBBLE = ctrl_out_t'(6'b000011);
  localparam ctrl_out_t OUT_REDIR  = ctrl_out_t'(6'b111111);
  localparam ctrl_out_t OUT_DRAIN  = ctrl_out_t'(6'b000110);
  function automatic int cyc_w(int a, int b, int c);
    return $clog2(((a > b ? a : b) > c ? (a > b ? a : b) : c) + 1);
  endfunction
endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequences pipe-register enables/flushes from hazards, dmem handshake and halt
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int BOOT_CYC       = BOOT_CYC_DEF,
  parameter int LOAD_STALL_CYC = LOAD_STALL_CYC_DEF,
  parameter int DRAIN_CYC      = DRAIN_CYC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hz_stall_i,
  input  logic             hz_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             halt_req_i,
  output logic             pc_en_o,
  output logic             pc_sel_o,
  output logic             if_de_en_o,
  output logic             if_de_flush_o,
  output logic             de_mw_en_o,
  output logic             de_mw_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int CW = cyc_w(BOOT_CYC, LOAD_STALL_CYC, DRAIN_CYC);
  ctrl_state_e state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  ctrl_out_t o;
  logic mem_wait, cyc_inc, stall_inc, flush_inc;
  assign mem_wait = dmem_req_i & ~dmem_ready_i;
  // The entry cycle from RUN counts as the first bubble/drain cycle, hence the -2 bounds.
  always_comb begin
    state_d = state_q;
    o = OUT_FREEZE;
    cyc_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      BOOT: begin
        o = OUT_BOOT;
        cyc_inc = 1'b1;
        if (int'(cyc_q) >= BOOT_CYC - 1) state_d = RUN;
      end
      RUN: begin
        if (mem_wait) state_d = MEM_WAIT;
        else if (hz_stall_i) begin
          o = OUT_BUBBLE;
          if (LOAD_STALL_CYC > 1) state_d = LOAD_STALL;
        end else if (hz_redirect_i) begin
          o = OUT_REDIR;
          flush_inc = 1'b1;
        end else if (halt_req_i) begin
          o = OUT_DRAIN;
          state_d = DRAIN_CYC > 1 ? DRAIN : HALT;
        end else o = OUT_RUN;
      end
      LOAD_STALL: if (!mem_wait) begin
        o = OUT_BUBBLE;
        cyc_inc = 1'b1;
        if (int'(cyc_q) >= LOAD_STALL_CYC - 2) state_d = RUN;
      end
      MEM_WAIT: if (dmem_ready_i) begin
        o = OUT_RUN;
        state_d = RUN;
      end
      DRAIN: if (!mem_wait) begin
        o = OUT_DRAIN;
        cyc_inc = 1'b1;
        if (int'(cyc_q) >= DRAIN_CYC - 2) state_d = HALT;
      end
      HALT: if (!halt_req_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
    cyc_d = (state_d != state_q) ? '0 : cyc_q + CW'(cyc_inc);
    stall_inc = ~o.pc_en & (state_q == RUN || state_q == LOAD_STALL || state_q == MEM_WAIT)
              & state_d != DRAIN & state_d != HALT;
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state_q <= BOOT;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
    end
  assign {pc_en_o, pc_sel_o, if_de_en_o, if_de_flush_o, de_mw_en_o, de_mw_flush_o} = o;
  assign halted_o = state_q == HALT;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .clear_i(~rst_ni),
    .en_i   (stall_inc),
    .cnt_o  (stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .clear_i(~rst_ni),
    .en_i   (flush_inc),
    .cnt_o  (flush_cnt_o)
  );
endmodule
